// File: rtl/cpu_flush_ctrl.sv
// Flush/squash controller for the PIC10-compatible core: drives the fetch->execute
// NOP mux and PC hold, and sequences post-reset warm-up and SLEEP/wake.
module cpu_flush_ctrl #(
    parameter int RESET_NOPS = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      inst_exec,
    input  logic             skip_cond,
    input  logic             pcl_write,
    input  logic             wake,
    output logic             nop_insert,
    output logic             pc_hold,
    output logic             sleeping,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    localparam logic [3:0]       WARM_LOAD = 4'(RESET_NOPS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] warm_cnt_r;
    logic [3:0] warm_cnt_nxt_s;
    logic       ctl_s;
    logic       skip_s;
    logic       slp_s;
    logic       flush_inc_s;

    // Baseline opcode decode of the word currently in execute.
    always_comb begin
        ctl_s  = (inst_exec[11:9] == 3'b101) | (inst_exec[11:8] == 4'b1001)
               | (inst_exec[11:8] == 4'b1000) | pcl_write;
        skip_s = ((inst_exec[11:8] == 4'b0110) | (inst_exec[11:8] == 4'b0111)
               | (inst_exec[11:6] == 6'b001011) | (inst_exec[11:6] == 6'b001111))
               & skip_cond;
        slp_s  = (inst_exec == 12'h003);
    end

    // Next-state and Mealy output logic.
    always_comb begin
        state_nxt_s    = state_r;
        warm_cnt_nxt_s = WARM_LOAD;
        nop_insert     = 1'b0;
        pc_hold        = 1'b0;
        sleeping       = 1'b0;
        flush_inc_s    = 1'b0;
        case (state_r)
            ST_WARMUP: begin
                nop_insert = 1'b1;
                if (warm_cnt_r <= 4'd1) begin
                    state_nxt_s    = ST_RUN;
                    warm_cnt_nxt_s = WARM_LOAD;
                end else begin
                    warm_cnt_nxt_s = warm_cnt_r - 4'd1;
                end
            end
            ST_RUN: begin
                if (slp_s) begin
                    nop_insert  = 1'b1;
                    pc_hold     = 1'b1;
                    state_nxt_s = ST_SLEEP;
                end else if (ctl_s | skip_s) begin
                    nop_insert  = 1'b1;
                    flush_inc_s = 1'b1;
                end else begin
                    nop_insert  = 1'b0;
                end
            end
            ST_SLEEP: begin
                nop_insert = 1'b1;
                pc_hold    = 1'b1;
                sleeping   = 1'b1;
                if (wake) begin
                    state_nxt_s = ST_WAKE;
                end else begin
                    state_nxt_s = ST_SLEEP;
                end
            end
            ST_WAKE: begin
                nop_insert  = 1'b1;
                state_nxt_s = ST_RUN;
            end
            default: begin
                nop_insert  = 1'b1;
                state_nxt_s = ST_WARMUP;
            end
        endcase
    end

    // State and warm-up counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_WARMUP;
            warm_cnt_r <= WARM_LOAD;
        end else begin
            state_r    <= state_nxt_s;
            warm_cnt_r <= warm_cnt_nxt_s;
        end
    end

    // Saturating squash statistics counter; holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (flush_inc_s && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end else begin
            flush_cnt <= flush_cnt;
        end
    end

endmodule

// File: tb/tb_cpu_flush_ctrl.sv
// Table-driven bench for cpu_flush_ctrl with an expected-value queue; a second
// instance with a 4-bit counter covers saturation under the same stimulus.
module tb_cpu_flush_ctrl;

    typedef struct {
        logic [11:0] inst;
        logic        sc;
        logic        pw;
        logic        wk;
        logic        nop;
        logic        hold;
        logic        slp;
        int          cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] inst_exec = 12'h000;
    logic        skip_cond = 1'b0;
    logic        pcl_write = 1'b0;
    logic        wake = 1'b0;
    logic        nop_insert, pc_hold, sleeping;
    logic [15:0] flush_cnt;
    logic        nop4, hold4, sleep4;
    logic [3:0]  flush_cnt4;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    cpu_flush_ctrl #(.RESET_NOPS(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .inst_exec(inst_exec), .skip_cond(skip_cond),
        .pcl_write(pcl_write), .wake(wake), .nop_insert(nop_insert),
        .pc_hold(pc_hold), .sleeping(sleeping), .flush_cnt(flush_cnt)
    );

    cpu_flush_ctrl #(.RESET_NOPS(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .inst_exec(inst_exec), .skip_cond(skip_cond),
        .pcl_write(pcl_write), .wake(wake), .nop_insert(nop4),
        .pc_hold(hold4), .sleeping(sleep4), .flush_cnt(flush_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] i, input logic sc, input logic pw,
                                input logic wk, input logic n, input logic h,
                                input logic s, input int c);
        vec_t v;
        v.inst = i; v.sc = sc; v.pw = pw; v.wk = wk;
        v.nop = n; v.hold = h; v.slp = s; v.cnt = c;
        return v;
    endfunction

    // Called just after a rising edge: drive, queue expectation, compare at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        inst_exec = v.inst; skip_cond = v.sc; pcl_write = v.pw; wake = v.wk;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, " nop_insert"}, int'(nop_insert), int'(e.nop));
        check({tag, " pc_hold"},    int'(pc_hold),    int'(e.hold));
        check({tag, " sleeping"},   int'(sleeping),   int'(e.slp));
        check({tag, " flush_cnt"},  int'(flush_cnt),  e.cnt);
        check({tag, " flush_cnt4"}, int'(flush_cnt4), (e.cnt > 15) ? 15 : e.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // warm-up, control transfers, skips, SLEEP with simultaneous wake, wake-up
        tbl.push_back(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(12'hA10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(12'h643, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(12'h643, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk(12'h900, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
        tbl.push_back(mk(12'h800, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4));
        tbl.push_back(mk(12'h022, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(12'h2C5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6));
        tbl.push_back(mk(12'h3C5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6));
        tbl.push_back(mk(12'h285, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6));
        tbl.push_back(mk(12'h745, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7));
        tbl.push_back(mk(12'h003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7));
        tbl.push_back(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7));
        tbl.push_back(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7));

        // reset state while rst is held
        @(negedge clk);
        check("reset nop_insert", int'(nop_insert), 1);
        check("reset pc_hold",    int'(pc_hold),    0);
        check("reset sleeping",   int'(sleeping),   0);
        check("reset flush_cnt",  int'(flush_cnt),  0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

        // enter SLEEP again, then async reset between edges
        apply(mk(12'h003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7), "sleep2 enter");
        apply(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7), "sleep2 hold");
        #2;
        rst = 1'b1;
        #1;
        check("async rst sleeping",   int'(sleeping),   0);
        check("async rst nop_insert", int'(nop_insert), 1);
        check("async rst pc_hold",    int'(pc_hold),    0);
        check("async rst flush_cnt",  int'(flush_cnt),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0), "rewarm1");
        apply(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0), "rewarm2");
        apply(mk(12'hC05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0), "rerun");

        // 17 GOTO/NOP pairs: 16-bit counter reaches 17, 4-bit one holds at 15
        for (int i = 0; i < 17; i++) begin
            apply(mk(12'hA10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i),     $sformatf("sat goto%0d", i));
            apply(mk(12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i + 1), $sformatf("sat nop%0d", i));
        end
        check("final flush_cnt4", int'(flush_cnt4), 15);
        check("final flush_cnt",  int'(flush_cnt),  17);
        check("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
